// File: rtl/lint_xbar_rr.sv
// NB_MASTER x NB_SLAVE data-memory crossbar: per-target round-robin arbitration, per-target
// ID FIFOs for in-order response routing, and an internal error slave for unmapped addresses.
module lint_xbar_rr #(
  parameter int unsigned NB_MASTER  = 3,
  parameter int unsigned NB_SLAVE   = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 2,
  parameter logic [31:0] ERR_RDATA  = 32'hBADACCE5
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   end_addr_i,
  input  logic [NB_MASTER-1:0]             mst_req_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0]  mst_addr_i,
  input  logic [NB_MASTER-1:0]             mst_we_i,
  input  logic [NB_MASTER*DATA_WIDTH/8-1:0] mst_be_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0]  mst_wdata_i,
  output logic [NB_MASTER-1:0]             mst_gnt_o,
  output logic [NB_MASTER-1:0]             mst_rvalid_o,
  output logic [NB_MASTER*DATA_WIDTH-1:0]  mst_rdata_o,
  output logic [NB_MASTER-1:0]             mst_err_o,
  output logic [NB_SLAVE-1:0]              slv_req_o,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]   slv_addr_o,
  output logic [NB_SLAVE-1:0]              slv_we_o,
  output logic [NB_SLAVE*DATA_WIDTH/8-1:0] slv_be_o,
  output logic [NB_SLAVE*DATA_WIDTH-1:0]   slv_wdata_o,
  input  logic [NB_SLAVE-1:0]              slv_gnt_i,
  input  logic [NB_SLAVE-1:0]              slv_rvalid_i,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0]   slv_rdata_i
);

  localparam int unsigned BeW    = DATA_WIDTH / 8;
  localparam int unsigned NbTgt  = NB_SLAVE + 1;
  localparam int unsigned ErrIdx = NB_SLAVE;
  localparam int unsigned IdW    = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int unsigned TgtW   = $clog2(NbTgt);
  localparam int unsigned CntW   = $clog2(MAX_OUTST + 1);
  localparam int unsigned PtrW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(ERR_RDATA);

  // (base + off) mod NB_MASTER, with off < NB_MASTER
  function automatic logic [IdW-1:0] rot_idx(input logic [IdW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NB_MASTER) sum = sum - NB_MASTER;
    return IdW'(sum);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MAX_OUTST - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  logic [IdW-1:0]  r_rr_ptr [NbTgt];
  logic [IdW-1:0]  r_fifo   [NbTgt][MAX_OUTST];
  logic [PtrW-1:0] r_wr_ptr [NbTgt];
  logic [PtrW-1:0] r_rd_ptr [NbTgt];
  logic [CntW-1:0] r_fill   [NbTgt];
  logic [CntW-1:0] r_cnt    [NB_MASTER];
  logic [TgtW-1:0] r_tgt    [NB_MASTER];
  logic            r_err_rvalid;

  logic [TgtW-1:0]       w_dec      [NB_MASTER];
  logic [NB_MASTER-1:0]  w_elig     [NbTgt];
  logic [IdW-1:0]        w_sel      [NbTgt];
  logic [IdW-1:0]        w_head     [NbTgt];
  logic [DATA_WIDTH-1:0] w_rsp_data [NbTgt];
  logic [NbTgt-1:0]      w_full;
  logic [NbTgt-1:0]      w_any;
  logic [NbTgt-1:0]      w_tgt_gnt;
  logic [NbTgt-1:0]      w_hs;
  logic [NbTgt-1:0]      w_rsp_vld;
  logic [NbTgt-1:0]      w_pop;
  logic [NB_MASTER-1:0]  w_mst_gnt;
  logic [NB_MASTER-1:0]  w_mst_dec;

  // The error slave accepts whenever offered; a full FIFO already masks its requesters.
  assign w_tgt_gnt = {1'b1, slv_gnt_i};
  assign w_rsp_vld = {r_err_rvalid, slv_rvalid_i};
  assign w_hs      = w_any & w_tgt_gnt;

  // Descending scan so the lowest matching slave wins on overlap.
  always_comb begin
    for (int m = 0; m < int'(NB_MASTER); m++) begin
      w_dec[m] = TgtW'(ErrIdx);
      for (int s = int'(NB_SLAVE) - 1; s >= 0; s--) begin
        if ((mst_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= start_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (mst_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= end_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_dec[m] = TgtW'(s);
        end
      end
    end
  end

  always_comb begin
    for (int t = 0; t < int'(NbTgt); t++) begin
      w_full[t] = (r_fill[t] == CntW'(MAX_OUTST));
      w_pop[t]  = w_rsp_vld[t] && (r_fill[t] != '0);
      w_head[t] = r_fifo[t][r_rd_ptr[t]];
    end
  end

  // A master may only add to an open target while below the outstanding limit.
  always_comb begin
    for (int t = 0; t < int'(NbTgt); t++) begin
      for (int m = 0; m < int'(NB_MASTER); m++) begin
        w_elig[t][m] = mst_req_i[m] && (w_dec[m] == TgtW'(t)) && !w_full[t] &&
                       ((r_cnt[m] == '0) ||
                        ((r_tgt[m] == TgtW'(t)) && (r_cnt[m] < CntW'(MAX_OUTST))));
      end
    end
  end

  // Scan from the farthest offset down so the nearest eligible index at/after ptr wins.
  always_comb begin
    for (int t = 0; t < int'(NbTgt); t++) begin
      w_sel[t] = '0;
      w_any[t] = 1'b0;
      for (int i = int'(NB_MASTER) - 1; i >= 0; i--) begin
        if (w_elig[t][rot_idx(r_rr_ptr[t], i)]) begin
          w_sel[t] = rot_idx(r_rr_ptr[t], i);
          w_any[t] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < int'(NB_SLAVE); s++) begin
      w_rsp_data[s] = slv_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
    end
    w_rsp_data[ErrIdx] = ErrData;
  end

  always_comb begin
    w_mst_gnt = '0;
    w_mst_dec = '0;
    for (int m = 0; m < int'(NB_MASTER); m++) begin
      for (int t = 0; t < int'(NbTgt); t++) begin
        if (w_hs[t] && (w_sel[t] == IdW'(m))) w_mst_gnt[m] = 1'b1;
        if (w_pop[t] && (w_head[t] == IdW'(m))) w_mst_dec[m] = 1'b1;
      end
    end
  end

  always_comb begin
    mst_gnt_o    = w_mst_gnt & ~{NB_MASTER{rst_i}};
    mst_rvalid_o = '0;
    mst_err_o    = '0;
    mst_rdata_o  = '0;
    for (int t = 0; t < int'(NbTgt); t++) begin
      if (w_pop[t] && !rst_i) begin
        mst_rvalid_o[w_head[t]] = 1'b1;
        mst_err_o[w_head[t]]    = (t == int'(ErrIdx));
        mst_rdata_o[int'(w_head[t])*DATA_WIDTH +: DATA_WIDTH] = w_rsp_data[t];
      end
    end
  end

  always_comb begin
    slv_req_o   = '0;
    slv_addr_o  = '0;
    slv_we_o    = '0;
    slv_be_o    = '0;
    slv_wdata_o = '0;
    for (int s = 0; s < int'(NB_SLAVE); s++) begin
      if (w_any[s] && !rst_i) begin
        slv_req_o[s] = 1'b1;
        slv_we_o[s]  = mst_we_i[w_sel[s]];
        slv_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH] =
            mst_addr_i[int'(w_sel[s])*ADDR_WIDTH +: ADDR_WIDTH];
        slv_be_o[s*BeW +: BeW] = mst_be_i[int'(w_sel[s])*BeW +: BeW];
        slv_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] =
            mst_wdata_i[int'(w_sel[s])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < int'(NbTgt); t++) begin
        r_rr_ptr[t] <= '0;
        r_wr_ptr[t] <= '0;
        r_rd_ptr[t] <= '0;
        r_fill[t]   <= '0;
        for (int k = 0; k < int'(MAX_OUTST); k++) r_fifo[t][k] <= '0;
      end
      for (int m = 0; m < int'(NB_MASTER); m++) begin
        r_cnt[m] <= '0;
        r_tgt[m] <= '0;
      end
      r_err_rvalid <= 1'b0;
    end else begin
      for (int t = 0; t < int'(NbTgt); t++) begin
        if (w_hs[t]) begin
          r_fifo[t][r_wr_ptr[t]] <= w_sel[t];
          r_wr_ptr[t]            <= ptr_inc(r_wr_ptr[t]);
          r_rr_ptr[t]            <= rot_idx(w_sel[t], 1);
        end
        if (w_pop[t]) r_rd_ptr[t] <= ptr_inc(r_rd_ptr[t]);
        r_fill[t] <= r_fill[t] + CntW'(w_hs[t]) - CntW'(w_pop[t]);
      end
      for (int m = 0; m < int'(NB_MASTER); m++) begin
        r_cnt[m] <= r_cnt[m] + CntW'(w_mst_gnt[m]) - CntW'(w_mst_dec[m]);
        if (w_mst_gnt[m]) r_tgt[m] <= w_dec[m];
      end
      // Write data to the error slave is simply dropped; only the response is generated.
      r_err_rvalid <= w_hs[ErrIdx];
    end
  end

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int t = 0; t < int'(NbTgt); t++) begin
        assert (!(w_rsp_vld[t] && (r_fill[t] == '0)))
          else $warning("lint_xbar_rr: response on target %0d with nothing outstanding dropped", t);
      end
    end
  end

endmodule

// File: tb/tb_lint_xbar_rr.sv
// Directed bench for lint_xbar_rr: a single-cycle vector table for decode, arbitration and muxing,
// plus per-cycle step tables for round-robin, outstanding limit, stalls, decode error and reset.
module tb_lint_xbar_rr;
  localparam int NM = 3;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [DW-1:0] W0 = 32'hDA7A_0000;
  localparam logic [DW-1:0] W1 = 32'hDA7A_0001;
  localparam logic [DW-1:0] W2 = 32'hDA7A_0002;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NS*AW-1:0] start_addr, end_addr;
  logic [NM-1:0]    mst_req, mst_we, mst_gnt, mst_rvalid, mst_err;
  logic [NM*AW-1:0] mst_addr;
  logic [NM*BW-1:0] mst_be;
  logic [NM*DW-1:0] mst_wdata, mst_rdata;
  logic [NS-1:0]    slv_req, slv_we, slv_gnt, slv_rvalid;
  logic [NS*AW-1:0] slv_addr;
  logic [NS*BW-1:0] slv_be;
  logic [NS*DW-1:0] slv_wdata, slv_rdata;
  int checks = 0;
  int failures = 0;

  // s0: 0x0000-0x0FFF, s1: 0x1000-0x1FFF, s2: 0x0800-0x2FFF (overlaps s0 and s1)
  assign start_addr = {32'h0000_0800, 32'h0000_1000, 32'h0000_0000};
  assign end_addr   = {32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF};

  always #5 clk = ~clk;

  lint_xbar_rr dut (
    .clk_i(clk), .rst_i(rst_i),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .mst_req_i(mst_req), .mst_addr_i(mst_addr), .mst_we_i(mst_we), .mst_be_i(mst_be),
    .mst_wdata_i(mst_wdata), .mst_gnt_o(mst_gnt), .mst_rvalid_o(mst_rvalid),
    .mst_rdata_o(mst_rdata), .mst_err_o(mst_err),
    .slv_req_o(slv_req), .slv_addr_o(slv_addr), .slv_we_o(slv_we), .slv_be_o(slv_be),
    .slv_wdata_o(slv_wdata), .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata)
  );

  typedef struct {
    logic [NM-1:0] req; logic [NM-1:0] we;
    logic [AW-1:0] a0; logic [AW-1:0] a1; logic [AW-1:0] a2;
    logic [NS-1:0] sgnt;
    logic [NS-1:0] e_sreq; logic [NM-1:0] e_mgnt; logic [AW-1:0] e_addr0;
    logic e_we0; logic [DW-1:0] e_wd0;
  } vec_t;

  typedef struct {
    logic rst; logic [NM-1:0] req;
    logic [AW-1:0] a0; logic [AW-1:0] a1; logic [AW-1:0] a2;
    logic [NS-1:0] sgnt; logic [NS-1:0] srv; logic [DW-1:0] srd;
    logic [NM-1:0] e_gnt; logic [NS-1:0] e_sreq; logic [NM-1:0] e_rv; logic [NM-1:0] e_err;
    int e_m; logic [DW-1:0] e_rd;
  } step_t;

  vec_t  vecs [10];
  step_t steps[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    mst_req    = '0;
    mst_addr   = '0;
    mst_we     = '0;
    mst_be     = {4'hC, 4'h3, 4'hF};
    mst_wdata  = {W2, W1, W0};
    slv_gnt    = '0;
    slv_rvalid = '0;
    slv_rdata  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  function automatic logic any_out();
    return |{mst_gnt, mst_rvalid, mst_rdata, mst_err, slv_req, slv_addr, slv_we, slv_be,
             slv_wdata};
  endfunction

  task automatic run_steps(input string tag);
    for (int k = 0; k < steps.size(); k++) begin
      @(negedge clk);
      rst_i      = steps[k].rst;
      mst_req    = steps[k].req;
      mst_addr   = {steps[k].a2, steps[k].a1, steps[k].a0};
      slv_gnt    = steps[k].sgnt;
      slv_rvalid = steps[k].srv;
      slv_rdata  = {steps[k].srd, steps[k].srd, steps[k].srd};
      #1;
      chk($sformatf("%s[%0d].gnt", tag, k), 32'(mst_gnt), 32'(steps[k].e_gnt));
      chk($sformatf("%s[%0d].slv_req", tag, k), 32'(slv_req), 32'(steps[k].e_sreq));
      chk($sformatf("%s[%0d].rvalid", tag, k), 32'(mst_rvalid), 32'(steps[k].e_rv));
      chk($sformatf("%s[%0d].err", tag, k), 32'(mst_err), 32'(steps[k].e_err));
      if (steps[k].e_rv != '0)
        chk($sformatf("%s[%0d].rdata", tag, k), mst_rdata[steps[k].e_m*DW +: DW], steps[k].e_rd);
    end
    @(negedge clk);
    clr_in();
    rst_i = 1'b0;
    steps.delete();
  endtask

  task automatic seq_rr();
    int ord [6];
    logic prev_hs;
    logic [AW-1:0] prev_a;
    ord = '{0, 1, 2, 0, 1, 2};
    prev_hs = 1'b0;
    prev_a  = '0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      mst_req    = (k < 6) ? 3'b111 : 3'b000;
      mst_addr   = {32'h108, 32'h104, 32'h100};
      slv_gnt    = 3'b111;
      slv_rvalid = {2'b00, prev_hs};
      slv_rdata  = {64'h0, 32'hCAFE_0000 | prev_a};
      #1;
      chk($sformatf("rr[%0d].gnt", k), 32'(mst_gnt), (k < 6) ? 32'(1 << ord[k]) : 32'h0);
      if (k > 0) begin
        chk($sformatf("rr[%0d].rvalid", k), 32'(mst_rvalid), 32'(1 << ord[k-1]));
        chk($sformatf("rr[%0d].rdata", k), mst_rdata[ord[k-1]*DW +: DW],
            32'hCAFE_0100 + 32'(4 * ord[k-1]));
        chk($sformatf("rr[%0d].err", k), 32'(mst_err), 32'h0);
      end
      prev_hs = slv_req[0] & slv_gnt[0];
      prev_a  = slv_addr[0 +: AW];
    end
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    rst_i = 1'b1;

    // Reset held with random inputs: every output must stay low.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mst_req    = NM'($urandom);
      mst_addr   = {$urandom, $urandom, $urandom};
      mst_we     = NM'($urandom);
      mst_be     = 12'($urandom);
      mst_wdata  = {$urandom, $urandom, $urandom};
      slv_gnt    = NS'($urandom);
      slv_rvalid = NS'($urandom);
      slv_rdata  = {$urandom, $urandom, $urandom};
      #1 chk($sformatf("reset_outputs[%0d]", k), 32'(any_out()), 32'h0);
    end
    @(negedge clk);
    rst_i = 1'b0;
    clr_in();
    #1 chk("idle_outputs", 32'(any_out()), 32'h0);

    // Single-cycle vectors, each from a fresh reset (RR pointers at 0).
    vecs[0] = '{3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b111, 3'b000, 3'b000, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{3'b001, 3'b000, 32'h100, 32'h0, 32'h0, 3'b111, 3'b001, 3'b001, 32'h100, 1'b0, W0};
    vecs[2] = '{3'b111, 3'b000, 32'h100, 32'h104, 32'h108, 3'b001,
                3'b001, 3'b001, 32'h100, 1'b0, W0};
    vecs[3] = '{3'b111, 3'b101, 32'h1000, 32'h2004, 32'h0008, 3'b111,
                3'b111, 3'b111, 32'h8, 1'b1, W2};
    vecs[4] = '{3'b110, 3'b010, 32'h0, 32'h10, 32'h20, 3'b000, 3'b001, 3'b000, 32'h10, 1'b1, W1};
    vecs[5] = '{3'b010, 3'b000, 32'h0, 32'h3000_0000, 32'h0, 3'b000,
                3'b000, 3'b010, 32'h0, 1'b0, 32'h0};
    vecs[6] = '{3'b111, 3'b000, 32'h0FFF, 32'h1000, 32'h2FFF, 3'b111,
                3'b111, 3'b111, 32'hFFF, 1'b0, W0};
    vecs[7] = '{3'b001, 3'b000, 32'h3000, 32'h0, 32'h0, 3'b111, 3'b000, 3'b001, 32'h0, 1'b0, 32'h0};
    vecs[8] = '{3'b111, 3'b000, 32'h0800, 32'h1800, 32'h2000, 3'b110,
                3'b111, 3'b110, 32'h800, 1'b0, W0};
    vecs[9] = '{3'b011, 3'b011, 32'h1004, 32'h0FFC, 32'h0, 3'b010,
                3'b011, 3'b001, 32'hFFC, 1'b1, W1};
    for (int v = 0; v < 10; v++) begin
      do_reset();
      mst_req  = vecs[v].req;
      mst_we   = vecs[v].we;
      mst_addr = {vecs[v].a2, vecs[v].a1, vecs[v].a0};
      slv_gnt  = vecs[v].sgnt;
      #1;
      chk($sformatf("vec[%0d].slv_req", v), 32'(slv_req), 32'(vecs[v].e_sreq));
      chk($sformatf("vec[%0d].gnt", v), 32'(mst_gnt), 32'(vecs[v].e_mgnt));
      chk($sformatf("vec[%0d].slv_addr0", v), slv_addr[0 +: AW], vecs[v].e_addr0);
      chk($sformatf("vec[%0d].slv_we0", v), 32'(slv_we[0]), 32'(vecs[v].e_we0));
      chk($sformatf("vec[%0d].slv_wdata0", v), slv_wdata[0 +: DW], vecs[v].e_wd0);
      chk($sformatf("vec[%0d].rvalid", v), 32'(mst_rvalid), 32'h0);
    end

    seq_rr();

    // Outstanding limit: master 0 to slave 1, third request waits for the first response.
    do_reset();
    steps.push_back('{0, 3'b001, 32'h1000, 0, 0, 3'b111, 3'b000, 0, 3'b001, 3'b010, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h1004, 0, 0, 3'b111, 3'b000, 0, 3'b001, 3'b010, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h1008, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h1008, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h1008, 0, 0, 3'b111, 3'b010, 32'hAAAA_0001,
                      3'b000, 3'b000, 3'b001, 3'b000, 0, 32'hAAAA_0001});
    steps.push_back('{0, 3'b001, 32'h1008, 0, 0, 3'b111, 3'b010, 32'hBBBB_0002,
                      3'b001, 3'b010, 3'b001, 3'b000, 0, 32'hBBBB_0002});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b010, 32'hCCCC_0003,
                      3'b000, 3'b000, 3'b001, 3'b000, 0, 32'hCCCC_0003});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    run_steps("outst");

    // Cross-target stall: master 0 pending on slave 0 may not open slave 2.
    do_reset();
    steps.push_back('{0, 3'b001, 32'h100, 0, 0, 3'b111, 3'b000, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h2000, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h2000, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b001, 32'h2000, 0, 0, 3'b111, 3'b001, 32'h5A5A_0000,
                      3'b000, 3'b000, 3'b001, 3'b000, 0, 32'h5A5A_0000});
    steps.push_back('{0, 3'b001, 32'h2000, 0, 0, 3'b111, 3'b000, 0, 3'b001, 3'b100, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b100, 32'h2C2C_0000,
                      3'b000, 3'b000, 3'b001, 3'b000, 0, 32'h2C2C_0000});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    run_steps("xstall");

    // Decode error: unmapped read is granted at once and answered by the error slave.
    do_reset();
    steps.push_back('{0, 3'b010, 0, 32'h3000_0000, 0, 3'b111, 3'b000, 0,
                      3'b010, 3'b000, 3'b000, 3'b000, 1, 0});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b000, 0,
                      3'b000, 3'b000, 3'b010, 3'b010, 1, 32'hBADA_CCE5});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    run_steps("decerr");

    // Reset mid-operation: in-flight reads dropped, late rvalid ignored, RR restarts at 0.
    do_reset();
    steps.push_back('{0, 3'b001, 32'h100, 0, 0, 3'b111, 3'b000, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b010, 0, 32'h104, 0, 3'b111, 3'b000, 0, 3'b010, 3'b001, 3'b000, 3'b000, 0, 0});
    steps.push_back('{1, 3'b111, 32'h100, 32'h104, 32'h108, 3'b111, 3'b001, 32'h1234,
                      3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b000, 0, 0, 0, 3'b111, 3'b001, 32'hDEAD_0000,
                      3'b000, 3'b000, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b111, 32'h100, 32'h104, 32'h108, 3'b111, 3'b000, 0,
                      3'b001, 3'b001, 3'b000, 3'b000, 0, 0});
    steps.push_back('{0, 3'b111, 32'h100, 32'h104, 32'h108, 3'b111, 3'b000, 0,
                      3'b010, 3'b001, 3'b000, 3'b000, 0, 0});
    run_steps("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
